// File: rtl/pe_edge_injector.sv
// pe_edge_injector: burst-command packet injector feeding a PE ingress port; optional counters via PE_INJECT_STATS_EN
package pe_types;
    localparam int PID_BITS = 4;
    typedef logic [PID_BITS-1:0] pid_t;
    typedef struct packed {
        pid_t        pid;
        logic [31:0] payload;
    } packet_t;
endpackage

module pe_edge_injector
    import pe_types::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PID_BITS-1:0]  cmd_pid,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 dat_valid,
    output logic                 dat_ready,
    input  logic [31:0]          dat_word,
    input  logic                 flush,
    output logic                 egress_empty,
    output logic [$bits(packet_t)-1:0] egress_rdata,
    input  logic                 egress_deq,
    output logic                 busy,
    output logic [31:0]          pkt_sent,
    output logic [31:0]          stall_cyc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  remaining;
    pid_t              cur_pid;
    packet_t           mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, cmd_fire, dat_fire, deq_fire;

    assign full         = count == FULL_CNT;
    assign empty        = count == '0;
    assign cmd_ready    = state == IDLE;
    assign dat_ready    = (state == BURST) && !full;
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign dat_fire     = dat_valid && dat_ready;
    assign deq_fire     = egress_deq && !empty;
    assign egress_empty = empty;
    assign egress_rdata = empty ? '0 : mem[rd_ptr];
    assign busy         = (state == BURST) || !empty;

    // Burst sequencing: a header opens a burst, the last word closes it, flush aborts it
    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = IDLE;
        else if (state == IDLE && cmd_fire && cmd_len != '0)
            state_nx = BURST;
        else if (state == BURST && dat_fire && remaining == LEN_W'(1))
            state_nx = IDLE;
    end

    // State register plus the per-burst pid and word countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            cur_pid   <= '0;
        end else begin
            state <= state_nx;
            if (flush)
                remaining <= '0;
            else if (cmd_fire) begin
                cur_pid   <= cmd_pid;
                remaining <= cmd_len;
            end else if (dat_fire)
                remaining <= remaining - LEN_W'(1);
        end
    end

    // Storage array needs no reset: reads are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (dat_fire && !flush)
            mem[wr_ptr] <= '{pid: cur_pid, payload: dat_word};
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (dat_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(dat_fire) - CW'(deq_fire);
        end
    end

`ifdef PE_INJECT_STATS_EN
    // Free-running statistics, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_sent  <= '0;
            stall_cyc <= '0;
        end else begin
            if (deq_fire && !flush)
                pkt_sent <= pkt_sent + 32'd1;
            if (state == BURST && dat_valid && full)
                stall_cyc <= stall_cyc + 32'd1;
        end
    end
`else
    assign pkt_sent  = '0;
    assign stall_cyc = '0;
`endif
endmodule

// File: tb/tb_pe_edge_injector.sv
// tb_pe_edge_injector: directed and random stimulus against a queue-based reference model
module tb_pe_edge_injector;
    import pe_types::*;

    localparam int DEPTH = 4;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, dat_valid = 0, flush = 0, egress_deq = 0;
    logic [3:0]  cmd_pid = 0;
    logic [7:0]  cmd_len = 0;
    logic [31:0] dat_word = 0;
    logic        cmd_ready, dat_ready, egress_empty, busy;
    logic [35:0] egress_rdata;
    logic [31:0] pkt_sent, stall_cyc;

    int n_cmp = 0, n_err = 0;

    logic [35:0] q[$];
    bit          in_burst;
    int          rem;
    logic [3:0]  m_pid;
    int unsigned m_sent, m_stall;

    pe_edge_injector #(.DEPTH(DEPTH), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pid(cmd_pid), .cmd_len(cmd_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_word(dat_word),
        .flush(flush),
        .egress_empty(egress_empty), .egress_rdata(egress_rdata), .egress_deq(egress_deq),
        .busy(busy), .pkt_sent(pkt_sent), .stall_cyc(stall_cyc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_burst = 0;
        rem      = 0;
        m_pid    = 0;
        m_sent   = 0;
        m_stall  = 0;
    endtask

    task automatic check_all();
        bit stats = 0;
`ifdef PE_INJECT_STATS_EN
        stats = 1;
`endif
        check("cmd_ready", 64'(cmd_ready), 64'(!in_burst));
        check("dat_ready", 64'(dat_ready), 64'(in_burst && q.size() < DEPTH));
        check("egress_empty", 64'(egress_empty), 64'(q.size() == 0));
        check("egress_rdata", 64'(egress_rdata), q.size() != 0 ? 64'(q[0]) : 64'd0);
        check("busy", 64'(busy), 64'(in_burst || q.size() != 0));
        check("pkt_sent", 64'(pkt_sent), stats ? 64'(m_sent) : 64'd0);
        check("stall_cyc", 64'(stall_cyc), stats ? 64'(m_stall) : 64'd0);
    endtask

    // One clock cycle: drive at negedge, compare, advance the model, cross the edge
    task automatic step(input bit cv, input logic [3:0] cp, input logic [7:0] cl,
                        input bit dv, input logic [31:0] dw, input bit dq, input bit fl);
        bit cf, df, qf;
        @(negedge clk);
        cmd_valid = cv; cmd_pid = cp; cmd_len = cl;
        dat_valid = dv; dat_word = dw; egress_deq = dq; flush = fl;
        #1;
        check_all();
        cf = cv && !in_burst;
        df = dv && in_burst && q.size() < DEPTH;
        qf = dq && q.size() != 0;
        if (in_burst && dv && q.size() == DEPTH)
            m_stall++;
        if (fl) begin
            q.delete();
            in_burst = 0;
            rem      = 0;
        end else begin
            if (qf) begin
                void'(q.pop_front());
                m_sent++;
            end
            if (df) begin
                q.push_back({m_pid, dw});
                rem--;
                if (rem == 0)
                    in_burst = 0;
            end
            if (cf) begin
                m_pid    = cp;
                rem      = int'(cl);
                in_burst = cl != 0;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        model_reset();
        #12;
        rst = 0;
        // Reset state
        step(0, 0, 0, 0, 0, 0, 0);

        // Burst pid=5 len=3 drained as it arrives
        step(1, 5, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hA, 1, 0);
        step(0, 0, 0, 1, 32'hB, 1, 0);
        step(0, 0, 0, 1, 32'hC, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Backpressure: len=6 into a 4-deep FIFO, then a single deq pulse
        step(1, 2, 6, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 32'h100 + i, 0, 0);
        step(0, 0, 0, 1, 32'h200, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h300 + i, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 32'h400 + i, 1, 0);

        // Zero-length header
        step(1, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Steady enq+deq around the pointer wrap with two entries held
        step(1, 9, 12, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h500, 0, 0);
        step(0, 0, 0, 1, 32'h501, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 32'h510 + i, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

        // Flush mid-burst with a word on the bus
        step(1, 3, 8, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h600, 0, 0);
        step(0, 0, 0, 1, 32'h601, 1, 0);
        step(0, 0, 0, 1, 32'h602, 0, 0);
        step(0, 0, 0, 1, 32'hDEAD, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 4, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h700, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset between edges mid-burst
        step(1, 6, 4, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h800, 0, 0);
        #2;
        rst = 1;
        #1;
        check("async_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("async_rst_empty", 64'(egress_empty), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk);
        cmd_valid = 0; dat_valid = 0; egress_deq = 0;
        rst = 0;
        step(1, 11, 2, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h900, 0, 0);
        step(0, 0, 0, 1, 32'h901, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 3, 4'($urandom), 8'($urandom_range(0, 5)),
                 $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 3);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pe_edge_injector.md
Name: pe_edge_injector

Overview:
- Host-side packet injector at an edge ingress port of the PE array (e.g. PE(0,0) west/north input).
- Accepts burst commands from the RISC-V side: one header (pid, length) followed by N 32-bit data words.
- Each data word becomes one packet_t {pid, payload}, buffered in an internal FIFO.
- The FIFO is presented to the PE with the same empty/rdata/deq contract as a PE ingress FIFO.

Parameters:
- DEPTH, 4, packet FIFO entries; power of two, at least 2.
- LEN_W, 8, width of the burst length field (max burst 2^LEN_W-1 words).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  burst header valid
- cmd_ready  out  1  header accepted when cmd_valid & cmd_ready
- cmd_pid  in  PID_BITS  pid stamped on every packet of the burst (pe_types pid_t)
- cmd_len  in  LEN_W  number of data words in the burst
- dat_valid  in  1  data word valid
- dat_ready  out  1  data word accepted when dat_valid & dat_ready
- dat_word  in  32  packet payload
- flush  in  1  synchronous abort: drop FIFO contents and any burst in progress
- egress_empty  out  1  FIFO empty, toward PE ingress_empty
- egress_rdata  out  $bits(packet_t)  head packet, toward PE ingress_rdata
- egress_deq  in  1  PE pops the head, from PE ingress_deq
- busy  out  1  burst in progress or FIFO non-empty
- pkt_sent  out  32  count of dequeued packets (see Optional Feature)
- stall_cyc  out  32  count of cycles with dat_valid high and dat_ready low (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, remaining=0, cur_pid=0.
- Output reset values: cmd_ready=1, dat_ready=0, egress_empty=1, egress_rdata=0, busy=0, pkt_sent=0, stall_cyc=0.
- FSM states:
  - IDLE:
    - cmd_ready=1, dat_ready=0.
    - On a cmd handshake, latch cur_pid=cmd_pid and remaining=cmd_len.
    - If cmd_len!=0, go to BURST; if cmd_len==0, stay in IDLE and emit no packet.
  - BURST:
    - cmd_ready=0, dat_ready=!full.
    - Each data handshake enqueues {pid:cur_pid, payload:dat_word} and decrements remaining.
    - The handshake with remaining==1 returns the FSM to IDLE on the next edge.
    - A new header can be accepted the cycle after the FSM returns to IDLE.
- FIFO:
  - Circular buffer with read and write pointers wrapping modulo DEPTH, plus an occupancy counter 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - egress_rdata = mem[rd_ptr] when non-empty, else 0.
- Latency:
  - A word accepted in cycle t drives egress_empty low in cycle t+1 (registered, no fall-through).
  - egress_deq in cycle t advances the head in t+1.
- Simultaneous enq+deq:
  - When not full, both take effect; count is unchanged.
  - When full, dat_ready is already 0 (computed from registered full), so no enqueue occurs.
  - The slot freed by a deq becomes visible to dat_ready the following cycle.
- egress_deq while empty: ignored, no pointer or count change.
- flush:
  - Takes effect on the next edge: FIFO emptied, FSM=IDLE, remaining=0.
  - Overrides any same-cycle cmd, dat or deq handshake; these are discarded and not counted.
- busy = (state==BURST) | !empty.
- Packet ordering: strictly FIFO; the pid is fixed per burst.

Optional Feature:
- Macro PE_INJECT_STATS_EN.
- Defined:
  - pkt_sent increments on each effective dequeue (deq & !empty & !flush).
  - stall_cyc increments on each cycle with state==BURST & dat_valid & full.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by rst only (flush does not clear them).
- Not defined: no counter flops exist; pkt_sent and stall_cyc are tied to 0.

Test Plan:
- Reset, then header pid=5 len=3 and words 0xA,0xB,0xC with egress_deq held 1 → PE sees packets {5,0xA},{5,0xB},{5,0xC} on consecutive cycles starting one cycle after the first data handshake; busy drops after the last deq; pkt_sent=3 with PE_INJECT_STATS_EN.
- DEPTH=4, header len=6, dat_valid held 1, egress_deq=0 → dat_ready falls after 4 accepts, egress_empty=0. Then pulse deq once → exactly one more word accepted, starting the cycle after the deq. stall_cyc counts every full cycle.
- Header len=0 → no packet enqueued, egress_empty stays 1, cmd_ready=1 on the next cycle, busy never asserts.
- FIFO holding 2 entries, simultaneous enq and deq for 10 cycles → count stays 2 and pointers wrap past DEPTH; payload order is preserved across the wrap.
- Mid-burst (len=8, 3 words sent, 2 still queued), assert flush together with dat_valid → next cycle egress_empty=1, FSM IDLE, cmd_ready=1; the flushed word never appears.
- Assert rst asynchronously mid-burst between clock edges → egress_empty=1 and cmd_ready=1 immediately, without waiting for an edge; the first header after release is accepted normally.
